ysyx_25020037_clint: RTL and testbench
======================================

// Module: ysyx_25020037_clint
// PURPOSE
//   Core-local timer: an AXI4 read-only slave that holds the 64-bit free-running mtime counter.
//   Sits directly downstream of the core-soc arbiter and consumes its clint_ar*/clint_r* channel.
//   The arbiter routes only LSU reads in 0x0200_0000-0x0200_FFFF here; this block has no write channel.
//   Single outstanding transaction, single-beat responses only.
// PARAMETERS
//   TICK_DIV  1   clk cycles per mtime increment (>=1); 1 = increment every cycle
// PORTS
//   clk      in   1   system clock, all state on posedge
//   rst      in   1   asynchronous, active-high reset
//   arready  out  1   AR ready
//   arvalid  in   1   AR valid
//   araddr   in   32  read address; only [15:0] decoded
//   arid     in   4   transaction ID, echoed on rid
//   arlen    in   8   burst length; must be 0
//   arsize   in   3   beat size; must be 3'b010 (4 bytes)
//   arburst  in   2   ignored
//   rready   in   1   R ready
//   rvalid   out  1   R valid
//   rresp    out  2   2'b00 OKAY, 2'b10 SLVERR
//   rdata    out  32  read data
//   rlast    out  1   always 1 when rvalid=1
//   rid      out  4   captured arid
// BEHAVIOUR
//   Reset (async): state=IDLE, arready=0, rvalid=0, rresp=0, rdata=0, rlast=0, rid=0, mtime=0,
//     prescaler=0, shadow_hi=0. arready rises to 1 on the first posedge after rst deasserts.
//   Timer: prescaler counts 0..TICK_DIV-1; on the cycle it equals TICK_DIV-1 it returns to 0 and
//     mtime increments by 1. mtime wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0. Counting never stalls on bus activity.
//   FSM states: IDLE, RESP.
//     IDLE: arready=1, rvalid=0. On arvalid&arready (cycle N): latch arid, decode, load rdata/rresp,
//       arready<=0, rvalid<=1, rlast<=1, go RESP. Response visible at cycle N+1 (1-cycle latency).
//     RESP: arready=0; hold rvalid, rdata, rresp, rid, rlast stable until rready=1.
//       On rvalid&rready: rvalid<=0, rlast<=0, arready<=1, go IDLE. No back-to-back: next AR accepted
//       no earlier than the cycle after the R handshake.
//   Decode (araddr[15:0], mtime = register value at cycle N, before that cycle's increment):
//     16'hBFF8: rdata=mtime[31:0]; shadow_hi<=mtime[63:32] (atomic 64-bit snapshot); rresp=OKAY.
//     16'hBFFC: rdata=shadow_hi (value captured by the last low-word read); rresp=OKAY.
//     any other offset, or arlen!=0, or arsize!=3'b010: rdata=0, rresp=SLVERR, shadow_hi unchanged,
//       still exactly one beat with rlast=1.
//   Software reads low then high to obtain a tear-free 64-bit value; a high read with no prior low
//     read returns 0 after reset.
//   rdata/rid/rresp hold their last value after the R handshake until the next AR handshake.
//   arvalid during RESP is ignored (arready=0); the request is taken once back in IDLE.
//   Reset during RESP aborts the response: rvalid drops immediately (async) and mtime clears.
// TESTING
//   1. Reset, TICK_DIV=1, idle 10 cycles, read 0xBFF8 -> rvalid one cycle after AR handshake, rresp=00,
//      rlast=1, rdata = cycle count since reset release at AR handshake.
//   2. TICK_DIV=4, preload mtime=64'h0000_0001_FFFF_FFFF via force at prescaler=3 -> next cycle mtime=
//      64'h0000_0002_0000_0000; read 0xBFF8 then 0xBFFC -> low = snapshot low, high=2 (no tearing).
//   3. Read 0xBFF8 with arid=4'hA, hold rready=0 for 5 cycles -> rvalid, rdata, rid=4'hA stable;
//      arready=0 throughout; second arvalid asserted meanwhile accepted only after the R handshake.
//   4. Read 0x0200_0000, then 0xBFF8 with arlen=1, then arsize=3'b001 -> each: one beat, rresp=2'b10,
//      rdata=0, rlast=1; a following 0xBFFC read returns the unchanged shadow_hi.
//   5. Preload mtime=64'hFFFF_FFFF_FFFF_FFFF, TICK_DIV=1 -> next cycle mtime=0; reads return 0/0.
//   6. Assert rst while in RESP -> rvalid=0 and arready=0 same cycle; after release a fresh 0xBFF8
//      read completes normally with a small mtime value.

Source files
------------

// File: rtl/ysyx_25020037_clint.sv
// ysyx_25020037_clint: read-only AXI4 slave exposing the free-running 64-bit mtime counter.
// Low-word reads snapshot the high word so a following high-word read is tear-free.
module ysyx_25020037_clint #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        arready,
    input  logic        arvalid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        rready,
    output logic        rvalid,
    output logic [1:0]  rresp,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic [3:0]  rid
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    typedef enum logic {IDLE, RESP} state_e;
    state_e        state_q, state_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   shadow_q, shadow_d, rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [3:0]    rid_q, rid_d;
    logic          arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic          tick, hs, done, lo, hi, ok;
    logic          unused_bits;
    assign unused_bits = ^{arburst, araddr[31:16]};
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    always_comb begin
        tick      = presc_q == PW'(TICK_DIV - 1);
        presc_d   = tick ? '0 : presc_q + 1'b1;
        mtime_d   = mtime_q + {63'd0, tick};
        hs        = arvalid && arready_q;
        done      = rvalid_q && rready;
        lo        = araddr[15:0] == 16'hBFF8;
        hi        = araddr[15:0] == 16'hBFFC;
        ok        = (lo || hi) && arlen == 8'd0 && arsize == 3'b010;
        state_d   = hs ? RESP : (done ? IDLE : state_q);
        // arready is registered, so it first rises one cycle after reset release
        arready_d = state_q == IDLE ? !hs : done;
        rvalid_d  = hs || (rvalid_q && !rready);
        rlast_d   = hs || (rlast_q && !rready);
        rdata_d   = hs ? (!ok ? 32'd0 : (lo ? mtime_q[31:0] : shadow_q)) : rdata_q;
        rresp_d   = hs ? (ok ? 2'b00 : 2'b10) : rresp_q;
        rid_d     = hs ? arid : rid_q;
        shadow_d  = hs && ok && lo ? mtime_q[63:32] : shadow_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mtime_q   <= '0;
            presc_q   <= '0;
            shadow_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rid_q     <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mtime_q   <= mtime_d;
            presc_q   <= presc_d;
            shadow_q  <= shadow_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
        end
    end
endmodule

// File: tb/tb_ysyx_25020037_clint.sv
// tb_ysyx_25020037_clint: random and directed reads against an arithmetic mtime model;
// expected beats are queued on AR acceptance and checked by an independent R-channel monitor.
module tb_ysyx_25020037_clint;
    localparam int DIV = 4;
    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  id;
    } exp_t;
    logic        clk = 1'b0, rst = 1'b1;
    logic        arready, arvalid = 1'b0, rready = 1'b1, rvalid, rlast;
    logic [31:0] araddr = '0, rdata;
    logic [3:0]  arid = '0, rid;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'b010;
    logic [1:0]  arburst = 2'b01, rresp;
    exp_t        q[$];
    int          n_cmp = 0, n_bad = 0;
    logic [63:0] cyc, base = '0, anch = '0;
    logic [31:0] sh = '0;

    ysyx_25020037_clint #(.TICK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .arready(arready), .arvalid(arvalid), .araddr(araddr),
        .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst), .rready(rready),
        .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid)
    );

    always #5 clk = ~clk;

    // mtime is the number of whole TICK_DIV periods since reset, shifted by any preload
    always @(posedge clk or posedge rst) cyc <= rst ? 64'd0 : cyc + 64'd1;

    function automatic logic [63:0] mt();
        return base + cyc / DIV - anch;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (!rst && rvalid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rvalid: got rvalid=1 expected no response at %0t", $time);
            end else begin
                chk("rdata", rdata, q[0].data);
                chk("rresp", rresp, q[0].resp);
                chk("rid", rid, q[0].id);
                chk("rlast", rlast, 1);
                chk("arready_in_resp", arready, 0);
                if (rready) void'(q.pop_front());
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] sz);
        exp_t e;
        logic ok, lo;
        araddr = a; arid = id; arlen = len; arsize = sz; arvalid = 1'b1;
        for (int k = 0; k < 100 && !arready; k++) @(negedge clk);
        chk("ar_timeout", arready, 1);
        lo = a[15:0] == 16'hBFF8;
        ok = (lo || a[15:0] == 16'hBFFC) && len == 8'd0 && sz == 3'b010;
        e.data = !ok ? 32'd0 : (lo ? mt() : {32'd0, sh});
        e.resp = ok ? 2'b00 : 2'b10;
        e.id = id;
        if (ok && lo) sh = mt() >> 32;
        q.push_back(e);
        @(negedge clk);
        arvalid = 1'b0;
        chk("r_latency", rvalid, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && rvalid; k++) @(negedge clk);
        chk("drain_timeout", rvalid, 0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [3:0] id = 4'h0,
                      input logic [7:0] len = 8'd0, input logic [2:0] sz = 3'b010);
        rready = 1'b1;
        issue(a, id, len, sz);
        drain();
    endtask

    task automatic preload(input logic [63:0] v);
        for (int k = 0; k < 2 * DIV && cyc % DIV != DIV - 2; k++) @(negedge clk);
        force dut.mtime_q = v;
        @(negedge clk);
        release dut.mtime_q;
        base = v;
        anch = cyc / DIV;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        sh = '0; base = '0; anch = '0;
        #1;
        chk("rst_rvalid", rvalid, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rid_rresp_rlast", {rid, rresp, rlast}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("arready_after_release", arready, 0);
        @(negedge clk);
        chk("arready_first_edge", arready, 1);
    endtask

    initial begin
        logic [31:0] a;
        repeat (2) @(negedge clk);
        do_reset();
        repeat (10) @(negedge clk);
        rd(32'h0200_BFF8, 4'h1);
        preload(64'h0000_0001_FFFF_FFFF);
        #1 chk("preload_carry_hold", dut.mtime_q, 64'h0000_0001_FFFF_FFFF);
        rd(32'h0200_BFF8, 4'h2);
        rd(32'h0200_BFFC, 4'h3);
        rready = 1'b0;
        issue(32'h0200_BFF8, 4'hA, 8'd0, 3'b010);
        araddr = 32'h0200_BFFC; arid = 4'h5; arvalid = 1'b1;
        repeat (5) @(negedge clk);
        rready = 1'b1;
        issue(32'h0200_BFFC, 4'h5, 8'd0, 3'b010);
        drain();
        rd(32'h0200_0000, 4'h6);
        rd(32'h0200_BFF8, 4'h7, 8'd1);
        rd(32'h0200_BFF8, 4'h8, 8'd0, 3'b001);
        rd(32'h0200_BFFC, 4'h9);
        preload(64'hFFFF_FFFF_FFFF_FFFF);
        rd(32'h0200_BFF8, 4'hB);
        rd(32'h0200_BFFC, 4'hC);
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: a = 32'h0200_BFF8;
                1: a = 32'h0200_BFFC;
                2: a = 32'h0200_0000 | ($urandom_range(0, 16'hFFFF) & 32'hFFFC);
                default: a = $urandom;
            endcase
            rready = 1'b1;
            issue(a, 4'($urandom), $urandom_range(0, 5) == 0 ? 8'd1 : 8'd0,
                  $urandom_range(0, 5) == 0 ? 3'b011 : 3'b010);
            if ($urandom_range(0, 1) == 1) begin
                rready = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                rready = 1'b1;
            end
            drain();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rready = 1'b0;
        issue(32'h0200_BFF8, 4'hD, 8'd0, 3'b010);
        #2 rst = 1'b1;
        #1;
        chk("abort_rvalid", rvalid, 0);
        chk("abort_arready", arready, 0);
        rready = 1'b1;
        @(negedge clk);
        do_reset();
        repeat (3) @(negedge clk);
        rd(32'h0200_BFF8, 4'hE);
        rd(32'h0200_BFFC, 4'hF);
        repeat (2) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
